// File: rtl/clk_tick_gen_if.sv
// clk_tick_gen_if: enable, per-channel divisor load and per-channel
// tick/sq/pend outputs of the tick generator.
interface clk_tick_gen_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32
);
   logic                    en;
   logic [NUM_CH*CNT_W-1:0] div_val;
   logic [NUM_CH-1:0]       div_load;
   logic [NUM_CH-1:0]       pend;
   logic [NUM_CH-1:0]       tick;
   logic [NUM_CH-1:0]       sq;

   modport master (
      output en, div_val, div_load,
      input  pend, tick, sq
   );

   modport slave (
      input  en, div_val, div_load,
      output pend, tick, sq
   );
endinterface

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: multi-channel tick/square generator with runt-free reloads.
// Optional TICK_PHASE_SYNC_EN adds a sync input that phase-aligns all channels.
module clk_tick_gen #(
   parameter int          NUM_CH      = 4,
   parameter int          CNT_W       = 32,
   parameter int unsigned DEFAULT_DIV = 100000000
) (
   input logic clk,
   input logic rst,
`ifdef TICK_PHASE_SYNC_EN
   input logic sync,
`endif
   clk_tick_gen_if.slave bus
);

   localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic              syn;
   logic [NUM_CH-1:0] pend_v;
   logic [NUM_CH-1:0] tick_v;
   logic [NUM_CH-1:0] sq_v;

`ifdef TICK_PHASE_SYNC_EN
   assign syn = sync;
`else
   assign syn = 1'b0;
`endif

   genvar i;
   for (i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] act;
      logic [CNT_W-1:0] nxt;
      logic [CNT_W-1:0] act_m;
      logic [CNT_W-1:0] lim;
      logic [CNT_W-1:0] val;
      logic             pend_q;
      logic             tick_q;
      logic             sq_q;
      logic             ld;
      logic             wrap;

      assign val   = bus.div_val[i*CNT_W +: CNT_W];
      assign ld    = bus.div_load[i];
      // divisor 0 behaves as 1, so lim never underflows
      assign act_m = (act == '0) ? ONE : act;
      assign lim   = act_m - ONE;
      assign wrap  = bus.en && (cnt >= lim);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt    <= '0;
            act    <= DEF;
            nxt    <= DEF;
            pend_q <= 1'b0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
         end else begin
            if (syn) begin
               cnt    <= '0;
               sq_q   <= 1'b0;
               tick_q <= 1'b0;
               if (pend_q) begin
                  act    <= nxt;
                  pend_q <= 1'b0;
               end
            end else if (wrap) begin
               cnt    <= '0;
               tick_q <= 1'b1;
               sq_q   <= ~sq_q;
               if (pend_q) begin
                  act    <= nxt;
                  pend_q <= 1'b0;
               end
            end else if (bus.en) begin
               cnt    <= cnt + ONE;
               tick_q <= 1'b0;
            end else begin
               tick_q <= 1'b0;
            end
            // a load in the boundary cycle lands after the old value applies
            if (ld) begin
               nxt    <= val;
               pend_q <= 1'b1;
            end
         end
      end

      assign pend_v[i] = pend_q;
      assign tick_v[i] = tick_q;
      assign sq_v[i]   = sq_q;
   end

   assign bus.pend = pend_v;
   assign bus.tick = tick_v;
   assign bus.sq   = sq_v;

endmodule

// File: tb/tb_clk_tick_gen.sv
// tb_clk_tick_gen: random enables/loads/resets checked cycle by cycle
// against a countdown reference model of each channel.
module tb_clk_tick_gen;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 32;
   localparam int DEF    = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   clk_tick_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

`ifdef TICK_PHASE_SYNC_EN
   logic sync;
`endif

   clk_tick_gen #(
      .NUM_CH(NUM_CH),
      .CNT_W(CNT_W),
      .DEFAULT_DIV(DEF)
   ) dut (
      .clk(clk),
      .rst(rst),
`ifdef TICK_PHASE_SYNC_EN
      .sync(sync),
`endif
      .bus(bus)
   );

   bit                      en_v;
   bit [NUM_CH-1:0]         ld_v;
   bit                      sy_v;
   int unsigned             val_v [NUM_CH];

   int unsigned             m_left [NUM_CH];
   int unsigned             m_act  [NUM_CH];
   int unsigned             m_nxt  [NUM_CH];
   bit                      m_pend [NUM_CH];
   bit                      m_tick [NUM_CH];
   int unsigned             m_nt   [NUM_CH];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   function automatic int unsigned per_of(input int unsigned d);
      return (d == 0) ? 1 : d;
   endfunction

   task automatic drive();
      bus.en <= en_v;
      for (int c = 0; c < NUM_CH; c++) begin
         bus.div_load[c] <= ld_v[c];
         bus.div_val[c*CNT_W +: CNT_W] <= val_v[c];
      end
`ifdef TICK_PHASE_SYNC_EN
      sync <= sy_v;
`endif
   endtask

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_act[c]  = DEF;
         m_nxt[c]  = DEF;
         m_pend[c] = 1'b0;
         m_tick[c] = 1'b0;
         m_nt[c]   = 0;
         m_left[c] = per_of(DEF);
      end
   endtask

   // one clock edge of behaviour: count down enabled cycles to the tick
   task automatic model_step();
      for (int c = 0; c < NUM_CH; c++) begin
         m_tick[c] = 1'b0;
         if (sy_v) begin
            m_nt[c] = 0;
            if (m_pend[c]) begin
               m_act[c]  = m_nxt[c];
               m_pend[c] = 1'b0;
            end
            m_left[c] = per_of(m_act[c]);
         end else if (en_v) begin
            m_left[c]--;
            if (m_left[c] == 0) begin
               m_tick[c] = 1'b1;
               m_nt[c]++;
               if (m_pend[c]) begin
                  m_act[c]  = m_nxt[c];
                  m_pend[c] = 1'b0;
               end
               m_left[c] = per_of(m_act[c]);
            end
         end
         if (ld_v[c]) begin
            m_nxt[c]  = val_v[c];
            m_pend[c] = 1'b1;
         end
      end
   endtask

   task automatic compare();
      logic [NUM_CH-1:0] et, es, ep;
      for (int c = 0; c < NUM_CH; c++) begin
         et[c] = m_tick[c];
         es[c] = m_nt[c][0];
         ep[c] = m_pend[c];
      end
      chk("tick", 32'(bus.tick), 32'(et));
      chk("sq",   32'(bus.sq),   32'(es));
      chk("pend", 32'(bus.pend), 32'(ep));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      en_v = 1'b0;
      ld_v = '0;
      sy_v = 1'b0;
      for (int c = 0; c < NUM_CH; c++) val_v[c] = 0;
   endtask

   initial begin
      int first;
      rst = 1'b1;
      clear_inputs();
      drive();
      model_reset();
      #12;
      chk("rst_tick", 32'(bus.tick), 32'd0);
      chk("rst_sq",   32'(bus.sq),   32'd0);
      chk("rst_pend", 32'(bus.pend), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // first tick lands DEF enabled cycles after release
      en_v  = 1'b1;
      drive();
      first = 0;
      for (int n = 1; n <= 12; n++) begin
         cycle();
         if (first == 0 && bus.tick[0]) first = n;
      end
      chk("first_tick_cycle", 32'(first), 32'(DEF));
      chk("ticks_in_12", m_nt[1], 32'd3);

      for (int k = 0; k < 4000; k++) begin
         en_v = ($urandom % 8) != 0;
         sy_v = 1'b0;
`ifdef TICK_PHASE_SYNC_EN
         sy_v = ($urandom % 60) == 0;
`endif
         for (int c = 0; c < NUM_CH; c++) begin
            ld_v[c]  = ($urandom % 12) == 0;
            val_v[c] = $urandom % 8;
         end
         drive();
         cycle();
         if (k % 900 == 450) begin
            #2 rst = 1'b1;
            #1;
            chk("async_rst_tick", 32'(bus.tick), 32'd0);
            chk("async_rst_sq",   32'(bus.sq),   32'd0);
            chk("async_rst_pend", 32'(bus.pend), 32'd0);
            model_reset();
            @(negedge clk);
            rst = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_tick_gen.md
Name: clk_tick_gen

Overview:
- Multi-channel programmable tick generator; next generation of the lab clock divider.
- Each channel emits a one-cycle enable pulse (tick) and a 50% square output (sq) from a runtime-loadable divisor. Downstream logic stays on clk and uses tick as an enable, not as a derived clock.
- Divisor changes take effect only at a period boundary, so no short or runt periods are produced.
- Sits between the board clock and the counter, 7-segment refresh and display logic.

Parameters:
- NUM_CH, 4, number of independent channels.
- CNT_W, 32, width of the divisor and counter per channel.
- DEFAULT_DIV, 100000000, divisor loaded at reset into every channel (1 Hz tick at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  global count enable; low freezes all counters.
- div_val  in  NUM_CH*CNT_W  divisor per channel; channel i uses bits [i*CNT_W +: CNT_W].
- div_load  in  NUM_CH  load strobe per channel; captures that channel's div_val slice.
- pend  out  NUM_CH  per channel, 1 = loaded divisor not yet applied.
- tick  out  NUM_CH  one-cycle pulse, once per period.
- sq  out  NUM_CH  toggles on each tick; period = 2*divisor clocks.

Behaviour:
- Per-channel registers:
  - cnt[CNT_W]: period counter.
  - act[CNT_W]: active divisor.
  - nxt[CNT_W]: pending divisor.
  - pend: pending flag.
- Divisor mapping: a stored value of 0 is treated as 1 (tick every enabled cycle). Divisor N gives a tick period of N enabled cycles.
- Reset values (async): cnt=0, act=DEFAULT_DIV, nxt=DEFAULT_DIV, pend=0, tick=0, sq=0.
- Wrap condition: en=1 and cnt >= act-1. The >= also recovers cleanly if cnt ever exceeds act.
- On wrap:
  - cnt <= 0.
  - tick <= 1 on the next cycle (registered; 1-cycle latency from the wrap condition).
  - sq <= ~sq.
  - If pend=1: act <= nxt and pend <= 0.
- Not wrapping, en=1: cnt <= cnt+1, tick <= 0.
- en=0: cnt, sq and act hold; tick <= 0; pending loads are still accepted.
- div_load=1:
  - nxt <= div_val slice; pend <= 1.
  - A later load before the boundary overwrites nxt (last load wins).
- div_load in the same cycle as a wrap:
  - The value currently in nxt (if pend) is applied at this wrap.
  - The new div_val lands in nxt with pend=1 and applies at the following wrap.
- No arithmetic overflow: cnt never exceeds act-1 in normal operation; act-1 is computed on the mapped (≥1) value.
- rst asserted mid-period: all channels return to reset values immediately; pending loads are discarded.
- Channels are fully independent. Only en (and optional sync) is shared.

Optional Feature:
- Macro: TICK_PHASE_SYNC_EN.
- Defined:
  - Adds input port sync (1 bit).
  - sync=1 for one cycle forces, in every channel: cnt <= 0, sq <= 0, tick <= 0.
  - It also applies any pending divisor (act <= nxt, pend <= 0).
  - sync has priority over wrap and over en.
  - Result: all channels are phase-aligned, with their first tick on cycle act after sync.
- Undefined: no sync port; channel phases depend only on reset and their own wraps.

Test Plan:
- Reset release, en=1, NUM_CH=4, CNT_W=32, DEFAULT_DIV=4: every channel ticks on cycles 4, 8, 12… after release; sq toggles on each tick (period 8); pend=0.
- Load ch1 div_val=3 mid-period at cnt=1: pend[1]=1; ch1 finishes its current 4-cycle period, then ticks every 3 cycles; pend[1] clears on the wrap; other channels unchanged.
- Load ch2 div_val=0: after the boundary, tick[2]=1 every enabled cycle and sq[2] toggles every cycle.
- Two loads on ch0 (5, then 7) before the boundary: only 7 is applied. Load in the exact wrap cycle: the old pending value applies now and the new value applies at the next wrap.
- en low for 10 cycles with ch3 at cnt=2: no ticks, cnt holds at 2; after en returns high, the next tick arrives 2 cycles later (div=4). Async rst pulse mid-period: outputs go to 0 without waiting for clk.
- With TICK_PHASE_SYNC_EN defined: channels with divisors 4 and 6, sync pulse → both sq=0 and cnt=0; ticks at +4/+6 cycles and coincide every 12 cycles.
